pwm_multi: RTL

Parametrised multi-channel PWM generator: one shared timebase drives CHANNELS independent comparators of WIDTH bits. Edge-aligned and center-aligned counting are supported. Period, mode and duty values are double-buffered in shadow registers and committed only at a period boundary, with a req/ack handshake. It is the generalised successor of the team's single-channel 8-bit PWM and sits between the control-register block and the output pins.

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_channel.sv | 21 ++
 rtl/pwm_multi.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM: counting mode and timebase direction encodings.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/pwm_channel.sv
// One PWM comparator: the output is registered from (cnt < duty) and held low while the timebase is disabled.
module pwm_channel #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] actDuty,
  output logic             pwmOut
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwmOut <= 1'b0;
    end else begin
      pwmOut <= en && (cnt < actDuty);
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/center-aligned timebase, double-buffered period/mode/duty
// committed at period boundaries with a one-cycle acknowledge.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode_in,
  input  logic [WIDTH-1:0]          period_in,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic                      update_req,
  output logic                      update_ack,
  output logic                      period_end,
  output logic [CHANNELS-1:0]       pwm_out
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cntNext;
  logic             dir;
  logic             dirNext;

  pwm_mode_t        actMode;
  pwm_mode_t        shMode;
  logic [WIDTH-1:0] actPeriod;
  logic [WIDTH-1:0] shPeriod;
  logic [WIDTH-1:0] actDuty [CHANNELS];
  logic [WIDTH-1:0] shDuty  [CHANNELS];
  logic             pending;

  logic             periodEndRaw;
  logic             boundary;
  logic             commit;

  // Last counter cycle of the period. With P = 1 in center mode there is no down-count,
  // so cnt == 1 on the way up is already the final cycle.
  always_comb begin
    periodEndRaw = 1'b0;
    if (actPeriod == '0) begin
      periodEndRaw = 1'b1;
    end else if (actMode == PWM_EDGE) begin
      periodEndRaw = (cnt == actPeriod);
    end else begin
      periodEndRaw = (cnt == WIDTH'(1)) && ((dir == DIR_DOWN) || (actPeriod == WIDTH'(1)));
    end
  end

  // A disabled timebase treats every cycle as a boundary so pending updates still land.
  assign boundary   = !en || periodEndRaw;
  assign commit     = boundary && pending;
  assign period_end = rst && en && periodEndRaw;

  always_comb begin
    cntNext = cnt;
    dirNext = dir;
    if (boundary) begin
      cntNext = '0;
      dirNext = DIR_UP;
    end else if (actMode == PWM_EDGE) begin
      cntNext = cnt + WIDTH'(1);
    end else if (dir == DIR_UP) begin
      if (cnt == actPeriod) begin
        cntNext = cnt - WIDTH'(1);
        dirNext = DIR_DOWN;
      end else begin
        cntNext = cnt + WIDTH'(1);
      end
    end else begin
      cntNext = cnt - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else begin
      cnt <= cntNext;
      dir <= dirNext;
    end
  end

  // A request arriving on a commit cycle refills the shadow after the older values were taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shMode   <= PWM_EDGE;
      shPeriod <= '0;
      pending  <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        shDuty[i] <= '0;
      end
    end else begin
      if (update_req) begin
        shMode   <= pwm_mode_t'(mode_in);
        shPeriod <= period_in;
        for (int i = 0; i < CHANNELS; i++) begin
          shDuty[i] <= duty_in[i*WIDTH +: WIDTH];
        end
      end
      if (update_req) begin
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      actMode    <= PWM_EDGE;
      actPeriod  <= '0;
      update_ack <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        actDuty[i] <= '0;
      end
    end else begin
      update_ack <= commit;
      if (commit) begin
        actMode   <= shMode;
        actPeriod <= shPeriod;
        for (int i = 0; i < CHANNELS; i++) begin
          actDuty[i] <= shDuty[i];
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : genChannel
    pwm_channel #(
      .WIDTH(WIDTH)
    ) uChannel (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .cnt    (cnt),
      .actDuty(actDuty[g]),
      .pwmOut (pwm_out[g])
    );
  end

endmodule
